// File: rtl/cut_sequencer.sv
// Cut sequencer: issues a programmed number of cut_o/cut_end handshakes with a dwell gap.
// Optional watchdog/FAULT state enabled by defining CUT_TIMEOUT_EN.
module cut_sequencer #(
  parameter int unsigned CNT_W          = 8,
  parameter int unsigned GAP_CYCLES     = 25000000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [CNT_W-1:0] n_cuts_i,
  input  logic             abort_i,
  output logic             cut_o,
  input  logic             cut_end_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fault_o,
  output logic [CNT_W-1:0] cuts_done_o
);

  localparam int unsigned TMR_W = 32;
  localparam logic [TMR_W-1:0] GapLast     = TMR_W'(GAP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TimeoutLast = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CUT,
    S_GAP,
    S_DONE
`ifdef CUT_TIMEOUT_EN
    , S_FAULT
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [2:0]       sync_q, sync_d;
  logic             cut_q, cut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef CUT_TIMEOUT_EN
  logic             fault_q, fault_d;
`endif
  logic             cut_end_rise;

  // cut_end_i is asynchronous; two flops resynchronise, the third gives edge detection
  assign sync_d       = {sync_q[1:0], cut_end_i};
  assign cut_end_rise = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          cnt_d = '0;
          if (n_cuts_i != '0) begin
            n_d     = n_cuts_i;
            timer_d = '0;
            state_d = S_CUT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CUT: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cut_end_rise) begin
          cnt_d   = cnt_q + CNT_W'(1);
          timer_d = '0;
          state_d = (cnt_d == n_q) ? S_DONE : S_GAP;
`ifdef CUT_TIMEOUT_EN
        end else if (timer_q == TimeoutLast) begin
          state_d = S_FAULT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`else
        end else if (timer_q != TimeoutLast) begin
          // no watchdog: timer only saturates so an endless wait never wraps it
          timer_d = timer_q + TMR_W'(1);
        end
`endif
      end
      S_GAP: begin
        // any cut_end_rise here is the tail of the previous cut and is ignored
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (timer_q == GapLast) begin
          timer_d = '0;
          state_d = S_CUT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
`ifdef CUT_TIMEOUT_EN
      S_FAULT: begin
        if (abort_i) state_d = S_IDLE;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // outputs registered from the next state so they change on the same edge
    cut_d  = (state_d == S_CUT);
    done_d = done_d | (state_d == S_DONE);
`ifdef CUT_TIMEOUT_EN
    busy_d  = (state_d == S_CUT) || (state_d == S_GAP) || (state_d == S_FAULT);
    fault_d = (state_d == S_FAULT);
`else
    busy_d  = (state_d == S_CUT) || (state_d == S_GAP);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
      sync_q  <= '0;
      cut_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CUT_TIMEOUT_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      sync_q  <= sync_d;
      cut_q   <= cut_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef CUT_TIMEOUT_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign cut_o       = cut_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign cuts_done_o = cnt_q;
`ifdef CUT_TIMEOUT_EN
  assign fault_o     = fault_q;
`else
  assign fault_o     = 1'b0;
`endif

endmodule
